// File: rtl/bus_arbiter_rr.sv
// Round-robin memory bus arbiter with registered one-hot grants,
// one-cycle turnaround and hold-time preemption of unlocked owners.
module bus_arbiter_rr #(
  parameter int NREQ     = 3,
  parameter int IDW      = 2,
  parameter int MAX_HOLD = 16
) (
  input  logic            MasterClock,
  input  logic            resetL,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] lock,
  output logic [NREQ-1:0] grant,
  output logic [NREQ-1:0] grantL,
  output logic            busy,
  output logic [IDW-1:0]  owner
);

  localparam int CW =
    (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HOLD_MAX =
    CW'(MAX_HOLD);
  localparam logic [CW-1:0] HOLD_LAST =
    CW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam bit PREEMPT = (MAX_HOLD != 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_RELEASE
  } state_t;

  state_t          r_state;
  state_t          w_state_n;
  logic [NREQ-1:0] r_grant;
  logic [NREQ-1:0] r_grantL;
  logic            r_busy;
  logic [IDW-1:0]  r_owner;
  logic [IDW-1:0]  r_ptr;
  logic [CW-1:0]   r_cnt;

  logic [NREQ-1:0] w_grant_n;
  logic [IDW-1:0]  w_owner_n;
  logic [IDW-1:0]  w_ptr_n;
  logic [CW-1:0]   w_cnt_n;

  logic [IDW-1:0]  w_hi_win;
  logic [IDW-1:0]  w_lo_win;
  logic            w_hi_any;
  logic            w_lo_any;
  logic [IDW-1:0]  w_win;
  logic            w_any;
  logic [NREQ-1:0] w_win_oh;
  logic            w_own_req;
  logic            w_own_lock;
  logic            w_others;
  logic            w_preempt;

  // Split scan: indices above the pointer take priority over
  // those at or below it, which gives the upward wrap order.
  always_comb begin
    w_hi_win = '0;
    w_lo_win = '0;
    w_hi_any = 1'b0;
    w_lo_any = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i] && (i > int'(r_ptr))) begin
        w_hi_win = IDW'(i);
        w_hi_any = 1'b1;
      end
      if (req[i] && (i <= int'(r_ptr))) begin
        w_lo_win = IDW'(i);
        w_lo_any = 1'b1;
      end
    end
  end

  assign w_win    = w_hi_any ? w_hi_win : w_lo_win;
  assign w_any    = w_hi_any | w_lo_any;
  assign w_win_oh =
    {{(NREQ-1){1'b0}}, 1'b1} << w_win;

  assign w_own_req  = |(req & r_grant);
  assign w_own_lock = |(lock & r_grant);
  assign w_others   = |(req & ~r_grant);
  assign w_preempt  = PREEMPT
                   && (r_cnt >= HOLD_LAST)
                   && !w_own_lock
                   && w_others;

  always_comb begin
    w_state_n = r_state;
    w_grant_n = r_grant;
    w_owner_n = r_owner;
    w_ptr_n   = r_ptr;
    w_cnt_n   = r_cnt;
    unique case (r_state)
      S_IDLE, S_RELEASE: begin
        if (w_any) begin
          w_state_n = S_GRANT;
          w_grant_n = w_win_oh;
          w_owner_n = w_win;
          w_cnt_n   = '0;
        end else begin
          w_state_n = S_IDLE;
          w_grant_n = '0;
        end
      end
      S_GRANT: begin
        if (!w_own_req || w_preempt) begin
          w_state_n = S_RELEASE;
          w_grant_n = '0;
          w_ptr_n   = r_owner;
          w_cnt_n   = '0;
        end else if (r_cnt != HOLD_MAX) begin
          w_cnt_n = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_grant_n = '0;
      end
    endcase
  end

  always_ff @(posedge MasterClock or negedge resetL) begin
    if (!resetL) begin
      r_state  <= S_IDLE;
      r_grant  <= '0;
      r_grantL <= '1;
      r_busy   <= 1'b0;
      r_owner  <= '0;
      r_ptr    <= IDW'(NREQ - 1);
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_n;
      r_grant  <= w_grant_n;
      r_grantL <= ~w_grant_n;
      r_busy   <= |w_grant_n;
      r_owner  <= w_owner_n;
      r_ptr    <= w_ptr_n;
      r_cnt    <= w_cnt_n;
    end
  end

  assign grant  = r_grant;
  assign grantL = r_grantL;
  assign busy   = r_busy;
  assign owner  = r_owner;

  a_onehot: assert property (
    @(posedge MasterClock) disable iff (!resetL)
    $onehot0(r_grant)
  );

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Scoreboard bench for bus_arbiter_rr: directed scenarios plus
// random req/lock traffic, checked against a cycle model.
module tb_bus_arbiter_rr;

  localparam int NREQ     = 3;
  localparam int IDW      = 2;
  localparam int MAX_HOLD = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] lock;
  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] grantL;
  logic            busy;
  logic [IDW-1:0]  owner;

  bus_arbiter_rr #(
    .NREQ(NREQ),
    .IDW(IDW),
    .MAX_HOLD(MAX_HOLD)
  ) dut (
    .MasterClock(clk),
    .resetL(rst_n),
    .req(req),
    .lock(lock),
    .grant(grant),
    .grantL(grantL),
    .busy(busy),
    .owner(owner)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NREQ-1:0] g;
    logic [IDW-1:0]  o;
    logic            b;
  } exp_t;

  exp_t q[$];
  int n_assert = 0;
  int n_fail   = 0;

  // Reference: who holds the bus, for how many cycles, and
  // whether the bus is in its turnaround gap.
  bit m_act;
  bit m_gap;
  int m_own;
  int m_held;
  int m_last;

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] want);
    n_assert++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, got, want, $time);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] r,
                              input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic bit others_req(input logic [NREQ-1:0] r,
                                    input int own);
    for (int k = 0; k < NREQ; k++)
      if (k != own && r[k]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_act  = 1'b0;
    m_gap  = 1'b0;
    m_own  = 0;
    m_held = 0;
    m_last = NREQ - 1;
  endtask

  task automatic model_step(input logic [NREQ-1:0] r,
                            input logic [NREQ-1:0] l);
    int w;
    if (m_act) begin
      if (!r[m_own] ||
          (MAX_HOLD != 0 && m_held >= MAX_HOLD &&
           !l[m_own] && others_req(r, m_own))) begin
        m_act  = 1'b0;
        m_gap  = 1'b1;
        m_last = m_own;
      end else begin
        m_held++;
      end
    end else begin
      m_gap = 1'b0;
      w = pick(r, m_last);
      if (w >= 0) begin
        m_act  = 1'b1;
        m_own  = w;
        m_held = 1;
      end
    end
  endtask

  task automatic drive(input logic [NREQ-1:0] r,
                       input logic [NREQ-1:0] l);
    exp_t e;
    @(negedge clk);
    req  = r;
    lock = l;
    model_step(r, l);
    e.g = m_act ? NREQ'(1 << m_own) : '0;
    e.o = IDW'(m_own);
    e.b = m_act;
    q.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_grant"},  grant,  0);
    check({tag, "_grantL"}, grantL, {NREQ{1'b1}});
    check({tag, "_busy"},   busy,   0);
    check({tag, "_owner"},  owner,  0);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2;
    check("grant_before_reset", grant, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk);
    @(negedge clk);
    req   = '0;
    lock  = '0;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin : monitor
    exp_t e;
    logic [NREQ-1:0] gl;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e  = q.pop_front();
        gl = ~e.g;
        check("grant",  grant,  e.g);
        check("grantL", grantL, gl);
        check("busy",   busy,   e.b);
        check("owner",  owner,  e.o);
      end
    end
  end

  initial begin : stim
    logic [NREQ-1:0] r;
    logic [NREQ-1:0] l;
    rst_n = 1'b0;
    req   = '0;
    lock  = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;

    repeat (5) drive(3'b111, 3'b000);
    repeat (4) drive(3'b110, 3'b000);
    repeat (3) drive(3'b100, 3'b000);
    repeat (3) drive(3'b000, 3'b000);

    repeat (24) drive(3'b011, 3'b000);
    repeat (3)  drive(3'b000, 3'b000);
    repeat (25) drive(3'b001, 3'b000);
    repeat (6)  drive(3'b011, 3'b000);
    repeat (3)  drive(3'b000, 3'b000);

    repeat (30) drive(3'b011, 3'b001);
    repeat (3)  drive(3'b010, 3'b001);
    repeat (3)  drive(3'b000, 3'b000);

    repeat (40) drive(3'b100, 3'b000);
    repeat (2)  drive(3'b000, 3'b000);

    r = '0;
    l = '0;
    for (int i = 0; i < 1500; i++) begin
      for (int b = 0; b < NREQ; b++) begin
        if ($urandom_range(7) == 0)  r[b] = ~r[b];
        if ($urandom_range(15) == 0) l[b] = ~l[b];
      end
      drive(r, l);
    end
    repeat (3) drive(3'b000, 3'b000);

    repeat (3) drive(3'b001, 3'b000);
    async_reset();
    repeat (3) drive(3'b010, 3'b000);
    repeat (2) drive(3'b000, 3'b000);

    repeat (3) @(posedge clk);
    #2;
    check("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
